// File: rtl/alu_shift_seq_if.sv
// Command/operand and result bundle for alu_shift_seq.
// Handshake: start is a request sampled only while the block is idle; busy marks an accepted
// op in flight; done is a one-cycle pulse on the cycle result, flags and err are refreshed.
interface alu_shift_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [5:0]       ctrl;
  logic             c_flag;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_s;
  logic             flag_v;
  logic             err;

  modport master (
    output start, ctrl, c_flag, a, b, shamt,
    input  busy, done, result, flag_c, flag_z, flag_s, flag_v, err
  );

  modport slave (
    input  start, ctrl, c_flag, a, b, shamt,
    output busy, done, result, flag_c, flag_z, flag_s, flag_v, err
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops and bit-serial shifts/rotates,
// with registered result, flags and error indication.
module alu_shift_seq #(
  parameter int WIDTH   = 16,
  parameter int SHW     = $clog2(WIDTH),
  parameter bit USE_CIN = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_shift_seq_if.slave bus,
  output logic [1:0]     o_dbg_state
);

  // Op codes written as ctrl[5:0]; the bit order is the reverse of the Ctrl0..Ctrl5 notation.
  localparam logic [5:0] OP_ADD = 6'b010010;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_OR  = 6'b010100;
  localparam logic [5:0] OP_NOT = 6'b001100;
  localparam logic [5:0] OP_XOR = 6'b011100;
  localparam logic [5:0] OP_AND = 6'b011000;
  localparam logic [5:0] OP_MOV = 6'b000000;
  localparam logic [5:0] OP_INC = 6'b110110;
  localparam logic [5:0] OP_DEC = 6'b000110;
  localparam logic [5:0] OP_SLA = 6'b001001;
  localparam logic [5:0] OP_SLL = 6'b000001;
  localparam logic [5:0] OP_ROL = 6'b010001;
  localparam logic [5:0] OP_SRA = 6'b001101;
  localparam logic [5:0] OP_SRL = 6'b000101;
  localparam logic [5:0] OP_ROR = 6'b010101;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_work;
  logic             r_c;
  logic             r_v;
  logic             r_err;

  logic [WIDTH-1:0] r_result;
  logic             r_fc;
  logic             r_fz;
  logic             r_fs;
  logic             r_fv;
  logic             r_err_q;
  logic             r_done;

  function automatic logic is_shift(input logic [5:0] op);
    return (op == OP_SLA) || (op == OP_SLL) || (op == OP_ROL) ||
           (op == OP_SRA) || (op == OP_SRL) || (op == OP_ROR);
  endfunction

  logic w_start_shift;
  assign w_start_shift = is_shift(bus.ctrl) && (bus.shamt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // SHIFT keeps one extra cycle after the last step so the exit is taken on counter==0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_start_shift ? S_SHIFT : S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_cin;
  logic             w_arith;
  logic             w_err;
  logic             w_c;
  logic             w_v;

  always_comb begin
    w_op2   = '0;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_res   = r_a;
    w_err   = 1'b0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (r_op)
      OP_ADD: begin w_arith = 1'b1; w_op2 = r_b;  w_cin = USE_CIN ? r_cin : 1'b0; end
      OP_SUB: begin w_arith = 1'b1; w_op2 = ~r_b; w_cin = USE_CIN ? r_cin : 1'b1; end
      OP_INC: begin w_arith = 1'b1; w_op2 = {{(WIDTH-1){1'b0}}, 1'b1}; end
      OP_DEC: begin w_arith = 1'b1; w_op2 = '1; end
      OP_OR:  w_res = r_a | r_b;
      OP_NOT: w_res = ~r_a;
      OP_XOR: w_res = r_a ^ r_b;
      OP_AND: w_res = r_a & r_b;
      OP_MOV, OP_SLA, OP_SLL, OP_ROL, OP_SRA, OP_SRL, OP_ROR: w_res = r_a;
      default: w_err = 1'b1;
    endcase
    w_sum = {1'b0, r_a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cin};
    if (w_arith) begin
      w_res = w_sum[WIDTH-1:0];
      w_c   = w_sum[WIDTH];
      w_v   = (r_a[WIDTH-1] == w_op2[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  logic [WIDTH-1:0] w_step;
  logic             w_step_c;
  logic             w_step_v;

  always_comb begin
    w_step   = r_work;
    w_step_c = r_c;
    w_step_v = r_v;
    case (r_op)
      OP_SLL: begin
        w_step   = {r_work[WIDTH-2:0], 1'b0};
        w_step_c = r_work[WIDTH-1];
      end
      OP_SLA: begin
        w_step   = {r_work[WIDTH-2:0], 1'b0};
        w_step_c = r_work[WIDTH-1];
        w_step_v = r_v | (r_work[WIDTH-1] ^ r_work[WIDTH-2]);
      end
      OP_ROL: begin
        w_step   = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
        w_step_c = r_work[WIDTH-1];
      end
      OP_SRL: begin
        w_step   = {1'b0, r_work[WIDTH-1:1]};
        w_step_c = r_work[0];
      end
      OP_SRA: begin
        w_step   = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_step_c = r_work[0];
      end
      OP_ROR: begin
        w_step   = {r_work[0], r_work[WIDTH-1:1]};
        w_step_c = r_work[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_cnt    <= '0;
      r_work   <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_fc     <= 1'b0;
      r_fz     <= 1'b0;
      r_fs     <= 1'b0;
      r_fv     <= 1'b0;
      r_err_q  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op   <= bus.ctrl;
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_cin  <= bus.c_flag;
            r_cnt  <= bus.shamt;
            r_work <= bus.a;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_EXEC: begin
          r_work <= w_res;
          r_c    <= w_c;
          r_v    <= w_v;
          r_err  <= w_err;
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_work <= w_step;
            r_c    <= w_step_c;
            r_v    <= w_step_v;
            r_cnt  <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          r_result <= r_work;
          r_fc     <= r_c;
          r_fv     <= r_v;
          r_fz     <= (r_work == '0);
          r_fs     <= r_work[WIDTH-1];
          r_err_q  <= r_err;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state == S_EXEC) || (r_state == S_SHIFT);
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.flag_c  = r_fc;
  assign bus.flag_z  = r_fz;
  assign bus.flag_s  = r_fs;
  assign bus.flag_v  = r_fv;
  assign bus.err     = r_err_q;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: one instance without carry-in and one with carry-in share stimulus;
// table vectors, hand-written multi-cycle sequences and random ops against a behavioural model.
module tb_alu_shift_seq;
  localparam int W = 16;

  typedef struct {
    logic [15:0] res;
    logic        c, z, s, v, err;
    int          lat;
  } res_t;

  typedef struct {
    string       nm;
    string       code;
    logic [15:0] a, b;
    logic [3:0]  sh;
    logic [15:0] e_res;
    logic        e_c, e_z, e_s, e_v, e_err;
    int          e_lat;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg0, dbg1;
  int         n_vec = 0;
  int         n_bad = 0;
  vec_t       vecs[$];

  string op_names [15] = '{"ADD", "SUB", "OR", "NOT", "XOR", "AND", "MOV", "INC", "DEC",
                           "SLA", "SLL", "ROL", "SRA", "SRL", "ROR"};
  string op_codes [15] = '{"010010", "010001", "001010", "001100", "001110", "000110", "000000",
                           "011011", "011000", "100100", "100000", "100010", "101100", "101000",
                           "101010"};

  alu_shift_seq_if #(.WIDTH(W)) bus0 ();
  alu_shift_seq_if #(.WIDTH(W)) bus1 ();

  alu_shift_seq #(.WIDTH(W), .USE_CIN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .o_dbg_state(dbg0));
  alu_shift_seq #(.WIDTH(W), .USE_CIN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg_state(dbg1));

  assign bus1.start  = bus0.start;
  assign bus1.ctrl   = bus0.ctrl;
  assign bus1.c_flag = bus0.c_flag;
  assign bus1.a      = bus0.a;
  assign bus1.b      = bus0.b;
  assign bus1.shamt  = bus0.shamt;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  // Ctrl0..Ctrl5 text, leftmost character is ctrl[0]
  function automatic logic [5:0] code_of(input string s);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = (s.getc(i) == 8'h31);
    return r;
  endfunction

  function automatic string name_of(input logic [5:0] ctrl);
    for (int i = 0; i < 15; i++) if (code_of(op_codes[i]) == ctrl) return op_names[i];
    return "BAD";
  endfunction

  function automatic res_t model(input logic [5:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] sh, input logic cin, input bit use_cin);
    res_t        r;
    string       nm;
    int unsigned x, op2, ci, sum, msb, lsb;
    int          n;
    nm = name_of(ctrl);
    n = int'(sh);
    x = a; op2 = 0; ci = 0;
    r.c = 1'b0; r.v = 1'b0; r.err = 1'b0; r.lat = 2;
    if (nm == "ADD" || nm == "SUB" || nm == "INC" || nm == "DEC") begin
      if (nm == "ADD") begin
        op2 = b; ci = use_cin ? 32'(cin) : 32'd0;
      end else if (nm == "SUB") begin
        op2 = 32'hFFFF - b; ci = use_cin ? 32'(cin) : 32'd1;
      end else if (nm == "INC") op2 = 1;
      else op2 = 32'hFFFF;
      sum = a + op2 + ci;
      x = sum % 32'h10000;
      r.c = (sum >= 32'h10000);
      r.v = ((a >= 32'h8000) == (op2 >= 32'h8000)) && ((x >= 32'h8000) != (a >= 32'h8000));
    end else if (nm == "OR")  x = a | b;
    else if (nm == "XOR") x = a ^ b;
    else if (nm == "AND") x = a & b;
    else if (nm == "NOT") x = 32'hFFFF - a;
    else if (nm == "MOV") x = a;
    else if (nm == "SLL" || nm == "SLA" || nm == "ROL" || nm == "SRL" || nm == "SRA" || nm == "ROR") begin
      r.lat = 2 + n;
      for (int i = 0; i < n; i++) begin
        msb = x / 32'h8000;
        lsb = x % 2;
        if (nm == "SLL" || nm == "SLA") begin
          r.c = (msb == 1);
          x = (x * 2) % 32'h10000;
          if (nm == "SLA" && (x / 32'h8000) != msb) r.v = 1'b1;
        end else if (nm == "ROL") begin
          r.c = (msb == 1);
          x = (x * 2) % 32'h10000 + msb;
        end else if (nm == "SRL") begin
          r.c = (lsb == 1); x = x / 2;
        end else if (nm == "SRA") begin
          r.c = (lsb == 1); x = x / 2 + msb * 32'h8000;
        end else begin
          r.c = (lsb == 1); x = x / 2 + lsb * 32'h8000;
        end
      end
    end else r.err = 1'b1;
    r.res = x[15:0];
    r.z = (x == 0);
    r.s = (x >= 32'h8000);
    return r;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver: one op, done awaited with a cycle budget; both instances compared to the model
  task automatic run_op(input string tag, input logic [5:0] ctrl, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh, input logic cin, output int lat);
    res_t m0, m1;
    int   bcy;
    bit   seen;
    m0 = model(ctrl, a, b, sh, cin, 1'b0);
    m1 = model(ctrl, a, b, sh, cin, 1'b1);
    @(negedge clk);
    bus0.ctrl = ctrl; bus0.a = a; bus0.b = b; bus0.shamt = sh; bus0.c_flag = cin;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus0.a = 16'($urandom); bus0.b = 16'($urandom); bus0.c_flag = ~cin;
    lat = 0; seen = 1'b0;
    bcy = bus0.busy ? 1 : 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus0.done) seen = 1'b1;
      else if (bus0.busy) bcy++;
    end
    chk({tag, " done seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(m0.lat));
    chk({tag, " busy cycles"}, 64'(bcy), 64'(m0.lat - 1));
    chk({tag, " result"}, 64'(bus0.result), 64'(m0.res));
    chk({tag, " C"}, 64'(bus0.flag_c), 64'(m0.c));
    chk({tag, " Z"}, 64'(bus0.flag_z), 64'(m0.z));
    chk({tag, " S"}, 64'(bus0.flag_s), 64'(m0.s));
    chk({tag, " V"}, 64'(bus0.flag_v), 64'(m0.v));
    chk({tag, " err"}, 64'(bus0.err), 64'(m0.err));
    chk({tag, " cin done"}, 64'(bus1.done), 64'd1);
    chk({tag, " cin result"}, 64'(bus1.result), 64'(m1.res));
    chk({tag, " cin C"}, 64'(bus1.flag_c), 64'(m1.c));
    chk({tag, " cin V"}, 64'(bus1.flag_v), 64'(m1.v));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 64'(bus0.done), 64'd0);
  endtask

  task automatic add(input string nm, input string code, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] sh, input logic [15:0] e_res, input logic e_c, input logic e_z,
                     input logic e_s, input logic e_v, input logic e_err, input int e_lat);
    vec_t v;
    v.nm = nm; v.code = code; v.a = a; v.b = b; v.sh = sh;
    v.e_res = e_res; v.e_c = e_c; v.e_z = e_z; v.e_s = e_s; v.e_v = e_v; v.e_err = e_err;
    v.e_lat = e_lat;
    vecs.push_back(v);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " busy"}, 64'(bus0.busy), 64'd0);
    chk({tag, " done"}, 64'(bus0.done), 64'd0);
    chk({tag, " result"}, 64'(bus0.result), 64'd0);
    chk({tag, " flags"}, 64'({bus0.flag_c, bus0.flag_z, bus0.flag_s, bus0.flag_v}), 64'd0);
    chk({tag, " err"}, 64'(bus0.err), 64'd0);
  endtask

  initial begin
    int lat, dones, first;
    rst_n = 1'b1;
    bus0.start = 1'b0; bus0.ctrl = '0; bus0.a = '0; bus0.b = '0; bus0.shamt = '0;
    bus0.c_flag = 1'b0;

    //          name       code      a         b         sh  res       C  Z  S  V  E  lat
    add("ADD_wrap", "010010", 16'hFFFF, 16'h0001, 0,  16'h0000, 1, 1, 0, 0, 0, 2);
    add("SUB_ovf",  "010001", 16'h8000, 16'h0001, 0,  16'h7FFF, 1, 0, 0, 1, 0, 2);
    add("SRA_3",    "101100", 16'h8001, 16'h0000, 3,  16'hF000, 0, 0, 1, 0, 0, 5);
    add("ROL_1",    "100010", 16'h8001, 16'h0000, 1,  16'h0003, 1, 0, 0, 0, 0, 3);
    add("SLA_1",    "100100", 16'h4000, 16'h0000, 1,  16'h8000, 0, 0, 1, 1, 0, 3);
    add("SLL_0",    "100000", 16'h1234, 16'h0000, 0,  16'h1234, 0, 0, 0, 0, 0, 2);
    add("BAD",      "111111", 16'h0000, 16'hFFFF, 0,  16'h0000, 0, 1, 0, 0, 1, 2);
    add("OR",       "001010", 16'h0F0F, 16'h00F0, 0,  16'h0FFF, 0, 0, 0, 0, 0, 2);
    add("NOT",      "001100", 16'hFFFF, 16'h1234, 0,  16'h0000, 0, 1, 0, 0, 0, 2);
    add("XOR",      "001110", 16'hA5A5, 16'hA5A5, 0,  16'h0000, 0, 1, 0, 0, 0, 2);
    add("AND",      "000110", 16'hF0F0, 16'hFF00, 0,  16'hF000, 0, 0, 1, 0, 0, 2);
    add("MOV",      "000000", 16'h8000, 16'h1111, 0,  16'h8000, 0, 0, 1, 0, 0, 2);
    add("INC_ovf",  "011011", 16'h7FFF, 16'h0000, 0,  16'h8000, 0, 0, 1, 1, 0, 2);
    add("DEC_0",    "011000", 16'h0000, 16'h0000, 0,  16'hFFFF, 0, 0, 1, 0, 0, 2);
    add("DEC_1",    "011000", 16'h0001, 16'h0000, 0,  16'h0000, 1, 1, 0, 0, 0, 2);
    add("SRL_15",   "101000", 16'hFFFF, 16'h0000, 15, 16'h0001, 1, 0, 0, 0, 0, 17);
    add("ROR_4",    "101010", 16'h0001, 16'h0000, 4,  16'h1000, 0, 0, 0, 0, 0, 6);
    add("SLA_2",    "100100", 16'h6000, 16'h0000, 2,  16'h8000, 1, 0, 1, 1, 0, 4);
    add("ADD_ovf",  "010010", 16'h7FFF, 16'h0001, 0,  16'h8000, 0, 0, 1, 1, 0, 2);

    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].nm, code_of(vecs[i].code), vecs[i].a, vecs[i].b, vecs[i].sh, 1'b0, lat);
      chk({vecs[i].nm, " tbl latency"}, 64'(lat), 64'(vecs[i].e_lat));
      chk({vecs[i].nm, " tbl result"}, 64'(bus0.result), 64'(vecs[i].e_res));
      chk({vecs[i].nm, " tbl CZSV"}, 64'({bus0.flag_c, bus0.flag_z, bus0.flag_s, bus0.flag_v}),
          64'({vecs[i].e_c, vecs[i].e_z, vecs[i].e_s, vecs[i].e_v}));
      chk({vecs[i].nm, " tbl err"}, 64'(bus0.err), 64'(vecs[i].e_err));
    end

    // carry-in variants on the USE_CIN=1 instance
    run_op("SUB_cin0", code_of("010001"), 16'h8000, 16'h0001, 4'd0, 1'b0, lat);
    chk("SUB_cin0 with-cin result", 64'(bus1.result), 64'h7FFE);
    chk("SUB_cin0 no-cin result", 64'(bus0.result), 64'h7FFF);
    run_op("ADD_cin1", code_of("010010"), 16'hFFFF, 16'h0000, 4'd0, 1'b1, lat);
    chk("ADD_cin1 with-cin result", 64'(bus1.result), 64'h0000);
    chk("ADD_cin1 with-cin C", 64'(bus1.flag_c), 64'd1);
    chk("ADD_cin1 no-cin result", 64'(bus0.result), 64'hFFFF);

    // start held high for the whole SRL by 15; operand a churns while busy
    @(negedge clk);
    bus0.ctrl = code_of("101000"); bus0.a = 16'hF0F0; bus0.b = '0; bus0.shamt = 4'd15;
    bus0.c_flag = 1'b0; bus0.start = 1'b1;
    @(posedge clk); #1;
    dones = 0; first = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        dones++;
        if (first == 0) first = i;
        bus0.start = 1'b0;
      end else if (bus0.start) bus0.a = 16'($urandom);
    end
    chk("hold_start done count", 64'(dones), 64'd1);
    chk("hold_start latency", 64'(first), 64'd17);
    chk("hold_start result", 64'(bus0.result), 64'h0001);
    chk("hold_start C", 64'(bus0.flag_c), 64'd1);
    chk("hold_start idle after", 64'(bus0.busy), 64'd0);

    // asynchronous reset in the middle of a shift
    @(negedge clk);
    bus0.ctrl = code_of("101000"); bus0.a = 16'hFFFF; bus0.shamt = 4'd10; bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero_outputs("mid_shift reset");
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus0.done) dones++;
    end
    chk("mid_shift reset no done", 64'(dones), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("BAD_after_rst", code_of("111111"), 16'h5A5A, 16'h0000, 4'd0, 1'b0, lat);
    chk("BAD_after_rst result", 64'(bus0.result), 64'h5A5A);
    chk("BAD_after_rst err", 64'(bus0.err), 64'd1);

    // randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      int          k;
      logic [5:0]  ctrl;
      k = $urandom_range(0, 15);
      ctrl = (k == 15) ? 6'($urandom) : code_of(op_codes[k]);
      run_op($sformatf("rnd%0d_%s", i, name_of(ctrl)), ctrl, 16'($urandom), 16'($urandom),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
